// File: rtl/mme_engine_if.sv
// mme_engine bus bundle: APB configuration port plus AXI memory port.
// slave = engine side, master = system/fabric side.
interface mme_engine_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/mme_engine.sv
// 4xN * Nx4 matrix-multiply engine: APB register file, AXI operand/result mover.
// Optional MME_PERF_CNT_EN adds the PERF_CYCLES busy-cycle counter at 0x214.
module mme_engine #(
  parameter logic [31:0] IP_VERSION = 32'h0001_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mme_engine_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_A_DAT, S_RD_B,
    S_RD_B_DAT, S_WR_ADDR, S_WR_DAT, S_WR_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_mat_cfg;
  logic [31:0]      r_a_addr;
  logic [31:0]      r_b_addr;
  logic [31:0]      r_c_addr;
  logic             r_done;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_k;
  logic [31:0]      r_a_base;
  logic [31:0]      r_b_base;
  logic [31:0]      r_c_base;
  logic [3:0]       r_beat;
  logic [31:0]      r_a [4];
  logic [31:0]      r_acc [16];
  logic [31:0]      w_prod [4];
  logic [31:0]      w_k_off;
  logic [31:0]      w_perf;
  logic [11:0]      w_off;
  logic             w_wr;
  logic             w_start;
  logic             w_r_hs;
  logic             w_w_hs;
  logic             w_unused;

  assign w_off    = bus.paddr[11:0];
  assign w_wr     = bus.psel & bus.penable & bus.pwrite;
  assign w_start  = w_wr && (w_off == 12'h20C) && bus.pwdata[0]
                    && (r_state == S_IDLE);
  assign w_r_hs   = bus.rvalid & bus.rready;
  assign w_w_hs   = bus.wvalid & bus.wready;
  assign w_k_off  = {{(28-CNT_W){1'b0}}, r_k, 4'b0000};
  assign w_unused = ^{bus.rresp, bus.bresp, bus.paddr[31:12]};

  assign bus.pready  = 1'b1;
  assign bus.pslverr = 1'b0;
  assign bus.arid    = 4'd0;
  assign bus.awid    = 4'd0;
  assign bus.arlen   = 4'd3;
  assign bus.awlen   = 4'd15;
  assign bus.arsize  = 3'b010;
  assign bus.awsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.awburst = 2'b01;
  assign bus.awaddr  = r_c_base;
  assign bus.wstrb   = 4'hF;
  assign bus.wdata   = r_acc[r_beat];
  assign bus.wlast   = (r_beat == 4'hF);

  // one multiplier per result row, fed by the current B beat
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_prod[r] = $signed(r_a[r]) * $signed(bus.rdata);
    end
  end

  // APB read mux, combinational during the access phase
  always_comb begin
    bus.prdata = 32'd0;
    if (bus.psel) begin
      unique case (1'b1)
        (w_off == 12'h000): bus.prdata = IP_VERSION;
        (w_off == 12'h100): bus.prdata = r_mat_cfg;
        (w_off == 12'h200): bus.prdata = r_a_addr;
        (w_off == 12'h204): bus.prdata = r_b_addr;
        (w_off == 12'h208): bus.prdata = r_c_addr;
        (w_off == 12'h210): bus.prdata = {31'd0, r_done};
        (w_off == 12'h214): bus.prdata = w_perf;
        default:            bus.prdata = 32'd0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and AXI handshake outputs
  always_comb begin
    w_next      = r_state;
    bus.arvalid = 1'b0;
    bus.araddr  = r_a_base + w_k_off;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (r_mat_cfg[CNT_W-1:0] == '0) ? S_WR_ADDR : S_RD_A;
        end
      end
      S_RD_A: begin
        bus.arvalid = 1'b1;
        if (bus.arready) w_next = S_RD_A_DAT;
      end
      S_RD_A_DAT: begin
        bus.rready = 1'b1;
        if (bus.rvalid && bus.rlast) w_next = S_RD_B;
      end
      S_RD_B: begin
        bus.arvalid = 1'b1;
        bus.araddr  = r_b_base + w_k_off;
        if (bus.arready) w_next = S_RD_B_DAT;
      end
      S_RD_B_DAT: begin
        bus.rready = 1'b1;
        if (bus.rvalid && bus.rlast) begin
          w_next = ((r_k + CNT_W'(1)) == r_n) ? S_WR_ADDR : S_RD_A;
        end
      end
      S_WR_ADDR: begin
        bus.awvalid = 1'b1;
        if (bus.awready) w_next = S_WR_DAT;
      end
      S_WR_DAT: begin
        bus.wvalid = 1'b1;
        if (bus.wready && bus.wlast) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // register file, operand latch at start, accumulate and beat counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mat_cfg <= '0;
      r_a_addr  <= '0;
      r_b_addr  <= '0;
      r_c_addr  <= '0;
      r_done    <= 1'b0;
      r_n       <= '0;
      r_k       <= '0;
      r_a_base  <= '0;
      r_b_base  <= '0;
      r_c_base  <= '0;
      r_beat    <= '0;
      for (int i = 0; i < 4; i++)  r_a[i]   <= '0;
      for (int i = 0; i < 16; i++) r_acc[i] <= '0;
    end else begin
      if (w_wr) begin
        unique case (1'b1)
          (w_off == 12'h100): r_mat_cfg <= bus.pwdata;
          (w_off == 12'h200): r_a_addr  <= bus.pwdata;
          (w_off == 12'h204): r_b_addr  <= bus.pwdata;
          (w_off == 12'h208): r_c_addr  <= bus.pwdata;
          default: ;
        endcase
      end
      if (w_start) begin
        r_done   <= 1'b0;
        r_n      <= r_mat_cfg[CNT_W-1:0];
        r_a_base <= r_a_addr;
        r_b_base <= r_b_addr;
        r_c_base <= r_c_addr;
        r_k      <= '0;
        r_beat   <= '0;
        for (int i = 0; i < 16; i++) r_acc[i] <= '0;
      end
      if (w_r_hs && r_state == S_RD_A_DAT) begin
        r_a[r_beat[1:0]] <= bus.rdata;
        r_beat <= bus.rlast ? 4'd0 : r_beat + 4'd1;
      end
      if (w_r_hs && r_state == S_RD_B_DAT) begin
        for (int r = 0; r < 4; r++) begin
          r_acc[r*4 + int'(r_beat[1:0])] <=
            r_acc[r*4 + int'(r_beat[1:0])] + w_prod[r];
        end
        r_beat <= bus.rlast ? 4'd0 : r_beat + 4'd1;
        if (bus.rlast) r_k <= r_k + CNT_W'(1);
      end
      if (w_w_hs && r_state == S_WR_DAT) r_beat <= r_beat + 4'd1;
      if (bus.bvalid && r_state == S_WR_RESP) r_done <= 1'b1;
    end
  end

`ifdef MME_PERF_CNT_EN
  logic [31:0] r_perf;

  // busy-cycle counter, restarted by each new operation
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_perf <= '0;
    else if (w_start)           r_perf <= '0;
    else if (r_state != S_IDLE) r_perf <= r_perf + 32'd1;
  end
  assign w_perf = r_perf;
`else
  assign w_perf = 32'd0;
`endif

endmodule

// File: tb/tb_mme_engine.sv
// Self-checking bench for mme_engine: register table, AXI memory model
// with optional random stalls, and a plain-arithmetic matrix reference.
module tb_mme_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mme_engine_if bus();

  mme_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem   [4096];
  logic [31:0] wmem  [4096];
  int          wstamp[4096];
  int ar_cnt = 0, aw_cnt = 0, bad_len = 0;
  bit stall = 1'b0;

  int a_m [4][16];
  int b_m [16][4];
  logic [31:0] c_ref [16];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // AXI slave memory model; reacts #1 after each edge to handshakes
  // sampled on the preceding falling edge
  initial begin : axi_slave
    burst_t rq[$];
    int rbeat, wbeat;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s, pend_b;
    logic [31:0] ara, awa, wbase, wd;
    logic [3:0] arl, awl;
    logic wl;
    rbeat = 0; wbeat = 0; pend_b = 0; wbase = '0;
    bus.arready = 0; bus.awready = 0; bus.wready = 0;
    bus.rvalid = 0; bus.rlast = 0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.bvalid = 0; bus.bresp = 2'b00;
    forever begin
      @(negedge clk);
      rst_s = rst_n;
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;
      ara = bus.araddr; arl = bus.arlen;
      awa = bus.awaddr; awl = bus.awlen;
      wd  = bus.wdata;  wl  = bus.wlast;
      @(posedge clk); #1;
      if (!rst_s) begin
        rq.delete(); rbeat = 0; wbeat = 0; pend_b = 0;
        bus.rvalid = 0; bus.bvalid = 0; bus.rlast = 0;
        bus.arready = 0; bus.awready = 0; bus.wready = 0;
      end else begin
        if (ar_hs) begin
          rq.push_back('{ara, arl});
          ar_cnt++;
          if (arl != 4'd3) bad_len++;
        end
        if (r_hs) begin
          if (rbeat == int'(rq[0].len)) begin
            void'(rq.pop_front());
            rbeat = 0;
          end else rbeat++;
        end
        if (aw_hs) begin
          wbase = awa; wbeat = 0; aw_cnt++;
          if (awl != 4'd15) bad_len++;
        end
        if (w_hs) begin
          if (wl != (wbeat == 15)) bad_len++;
          wmem[widx(wbase + 32'(4*wbeat))] = wd;
          wstamp[widx(wbase + 32'(4*wbeat))] = aw_cnt;
          wbeat++;
          if (wl) pend_b = 1;
        end
        if (!(bus.rvalid && !r_hs)) begin
          if (rq.size() > 0 && (!stall || $urandom_range(3) != 0)) begin
            bus.rvalid = 1;
            bus.rdata  = mem[widx(rq[0].addr + 32'(4*rbeat))];
            bus.rlast  = (rbeat == int'(rq[0].len));
            bus.rresp  = stall ? 2'($urandom_range(3)) : 2'b00;
          end else begin
            bus.rvalid = 0;
            bus.rlast  = 0;
          end
        end
        if (b_hs) bus.bvalid = 0;
        if (!bus.bvalid && pend_b && (!stall || $urandom_range(2) == 0)) begin
          bus.bvalid = 1;
          bus.bresp  = stall ? 2'($urandom_range(3)) : 2'b00;
          pend_b = 0;
        end
        bus.arready = !stall || ($urandom_range(1) == 1);
        bus.awready = !stall || ($urandom_range(2) == 0);
        bus.wready  = !stall || ($urandom_range(1) == 1);
      end
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1;
    bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1;
    @(posedge clk); #1;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a;
    @(posedge clk); #1;
    bus.penable = 1;
    @(negedge clk);
    d = bus.prdata;
    @(posedge clk); #1;
    bus.psel = 0; bus.penable = 0;
  endtask

  // mode 0: bytes 0..255, 1: all 0x7FFFFFFF, 2: full 32-bit signed
  task automatic run_op(input int n, input int mode, input bit busy_cmd);
    logic [31:0] st;
    int polls, ar0, aw0, bad0, stale;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < n; k++) begin
        a_m[i][k] = (mode == 0) ? int'($urandom_range(255)) :
                    (mode == 1) ? 32'h7FFF_FFFF : int'($urandom);
        b_m[k][i] = (mode == 0) ? int'($urandom_range(255)) :
                    (mode == 1) ? 32'h7FFF_FFFF : int'($urandom);
      end
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        mem[widx(32'(16*k + 4*i))]          = a_m[i][k];
        mem[widx(32'h1000 + 32'(16*k + 4*i))] = b_m[k][i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < n; k++)
          s += 64'(longint'(a_m[i][k]) * longint'(b_m[k][j]));
        c_ref[i*4+j] = s[31:0];
      end
    end
    apb_write(32'h100, 32'(n));
    apb_write(32'h200, 32'h0);
    apb_write(32'h204, 32'h1000);
    apb_write(32'h208, 32'h2000);
    ar0 = ar_cnt; aw0 = aw_cnt; bad0 = bad_len;
    apb_write(32'h20C, 32'h1);
    if (n > 0) begin
      apb_read(32'h210, st);
      check($sformatf("done_clear n=%0d", n), st, 32'h0);
    end
    if (busy_cmd) begin
      apb_write(32'h20C, 32'h1);
      apb_write(32'h200, 32'h3000);
    end
    polls = 0;
    do begin
      apb_read(32'h210, st);
      polls++;
    end while (st[0] == 1'b0 && polls < 3000);
    check($sformatf("done n=%0d", n), st, 32'h1);
    repeat (busy_cmd ? 60 : 10) @(posedge clk);
    stale = 0;
    for (int e = 0; e < 16; e++) begin
      check($sformatf("C[%0d] n=%0d m=%0d", e, n, mode),
            wmem[widx(32'h2000 + 32'(4*e))], c_ref[e]);
      if (wstamp[widx(32'h2000 + 32'(4*e))] != aw_cnt) stale++;
    end
    check($sformatf("c_fresh n=%0d", n), 32'(stale), 32'd0);
    check($sformatf("ar_bursts n=%0d", n), 32'(ar_cnt - ar0), 32'(2*n));
    check($sformatf("aw_bursts n=%0d", n), 32'(aw_cnt - aw0), 32'd1);
    check($sformatf("burst_fmt n=%0d", n), 32'(bad_len - bad0), 32'd0);
  endtask

  initial begin : main
    reg_vec_t vecs[14];
    logic [31:0] rd;
    int ar0, waited;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0; wmem[i] = '0; wstamp[i] = 0;
    end

    vecs[0]  = '{1'b0, 32'h000, 32'h0,    32'h0001_0000};
    vecs[1]  = '{1'b0, 32'h210, 32'h0,    32'h0};
    vecs[2]  = '{1'b0, 32'h100, 32'h0,    32'h0};
    vecs[3]  = '{1'b1, 32'h100, 32'h4,    32'h0};
    vecs[4]  = '{1'b1, 32'h200, 32'h0,    32'h0};
    vecs[5]  = '{1'b1, 32'h204, 32'h1000, 32'h0};
    vecs[6]  = '{1'b1, 32'h208, 32'h2000, 32'h0};
    vecs[7]  = '{1'b0, 32'h100, 32'h0,    32'h4};
    vecs[8]  = '{1'b0, 32'h200, 32'h0,    32'h0};
    vecs[9]  = '{1'b0, 32'h204, 32'h0,    32'h1000};
    vecs[10] = '{1'b0, 32'h208, 32'h0,    32'h2000};
    vecs[11] = '{1'b0, 32'h20C, 32'h0,    32'h0};
    vecs[12] = '{1'b1, 32'h300, 32'hABCD, 32'h0};
    vecs[13] = '{1'b0, 32'h300, 32'h0,    32'h0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_valids",
          {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
           bus.bready}, 32'h0);
    check("reset_prdata", bus.prdata, 32'h0);
    check("fixed_fields",
          {bus.arid, bus.awid, bus.arsize, bus.awsize, bus.arburst,
           bus.awburst, bus.wstrb, bus.pready, bus.pslverr, 5'd0},
          {4'd0, 4'd0, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF,
           1'b1, 1'b0, 5'd0});

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else begin
        apb_read(vecs[i].addr, rd);
        check($sformatf("reg_vec%0d @%h", i, vecs[i].addr), rd,
              vecs[i].exp);
      end
    end
    apb_read(32'h214, rd);
    check("perf_reset", rd, 32'h0);

    stall = 0;
    run_op(4, 0, 0);
    run_op(8, 0, 0);
    run_op(12, 0, 0);
    run_op(16, 0, 0);
    run_op(4, 1, 0);
    check("ovf_c00", wmem[widx(32'h2000)], 32'd4);
    stall = 1;
    run_op(4, 1, 0);
    check("ovf_c33_stall", wmem[widx(32'h203C)], 32'd4);
    run_op(16, 2, 0);
    run_op(0, 0, 0);
    run_op(4, 2, 1);
`ifdef MME_PERF_CNT_EN
    apb_read(32'h214, rd);
    check("perf_nonzero", {31'd0, rd != 0}, 32'h1);
    begin
      logic [31:0] rd2;
      apb_read(32'h214, rd2);
      check("perf_hold", rd2, rd);
    end
`endif

    apb_write(32'h100, 32'd8);
    ar0 = ar_cnt;
    apb_write(32'h20C, 32'h1);
    waited = 0;
    while (ar_cnt < ar0 + 3 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    check("midrun_reached", {31'd0, ar_cnt >= ar0 + 3}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_valids_drop",
          {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
           bus.bready}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apb_read(32'h210, rd);
    check("rst_status", rd, 32'h0);
    apb_read(32'h100, rd);
    check("rst_matcfg", rd, 32'h0);
    run_op(4, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mme_engine.md
Name: mme_engine

Overview:
- 4xN by Nx4 matrix-multiply engine producing a 4x4 result C = A x B.
- Software configures and controls it through an APB slave register file.
- Operands are fetched and the result is stored through an AXI master (AR/R/AW/W/B) on a 32-bit data bus.
- Sits between the system APB configuration bus and the memory AXI fabric.

Parameters:
- IP_VERSION, 32'h0001_0000, value returned by the IP_VER register.
- CNT_W, 16, width of the k-loop counter; matrix width uses MAT_CFG[CNT_W-1:0].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  32  APB address; only [11:0] decoded.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  tied to 1.
- pslverr  out  1  tied to 0.
- arid/awid  out  4  AXI IDs, tied to 0.
- araddr/awaddr  out  32  AXI burst start addresses.
- arlen/awlen  out  4  AXI burst lengths.
- arsize/awsize  out  3  fixed 3'b010.
- arburst/awburst  out  2  fixed INCR (2'b01).
- arvalid/awvalid  out  1; arready/awready  in  1.
- rdata  in  32; rresp  in  2; rlast, rvalid  in  1; rready  out  1.
- wdata  out  32; wstrb  out  4 (always 4'hF); wlast, wvalid  out  1; wready  in  1.
- bresp  in  2; bvalid  in  1; bready  out  1.

Behaviour:
- Registers (32-bit, byte offsets):
  - 0x000 IP_VER: RO, returns IP_VERSION.
  - 0x100 MAT_CFG: RW, matrix width N.
  - 0x200 A_ADDR, 0x204 B_ADDR, 0x208 C_ADDR: RW, full 32 bits.
  - 0x20C CMD: WO, reads 0; writing bit0=1 starts an operation.
  - 0x210 STATUS: RO, bit0 = done.
  - Unmapped offsets read 0; writes to them are ignored.
- APB: zero wait states. Writes take effect on psel&penable&pwrite. prdata is valid combinationally during the access phase.
- Reset: all RW registers 0, done=0, FSM IDLE, all AXI valid/ready outputs 0, prdata 0.
- Memory layout:
  - A is column-major: column k occupies 4 words at A_ADDR+16k, holding A[0..3][k].
  - B is row-major: row k occupies 4 words at B_ADDR+16k, holding B[k][0..3].
  - C is row-major: 16 words at C_ADDR.
- FSM:
  - IDLE: CMD start -> clear done, zero the 16 accumulators, k=0.
  - If N==0, go directly to WR_ADDR. Otherwise go to RD_A.
  - RD_A: arvalid with araddr=A_ADDR+16k, arlen=3. On handshake go to RD_A_DAT.
  - RD_A_DAT: rready=1; latch 4 beats into a[0..3]. On rlast go to RD_B.
  - RD_B: araddr=B_ADDR+16k, arlen=3. On handshake go to RD_B_DAT.
  - RD_B_DAT: on beat c, acc[r][c] += a[r]*rdata for r=0..3 (4 signed 32x32 multipliers). On rlast: k++; if k==N go to WR_ADDR, else go to RD_A.
  - WR_ADDR: awvalid, awaddr=C_ADDR, awlen=15. On handshake go to WR_DAT.
  - WR_DAT: 16 beats of acc in row-major order; wlast on beat 15; advance the beat counter only on wvalid&wready. After the last beat go to WR_RESP.
  - WR_RESP: bready=1. On bvalid: done=1, go to IDLE.
- Arithmetic: signed 32-bit operands, 32-bit two's-complement accumulators (wrap-around); results equal the low 32 bits of the exact sum.
- Valid/data outputs hold stable until their handshake completes. Backpressure is allowed on every channel.
- Non-OKAY rresp/bresp are ignored.
- CMD writes while busy are ignored. Config register writes while busy are accepted but do not affect the running operation; operands are latched at start.
- done stays 1 until the next start.
- rst_n low mid-operation: FSM returns to IDLE immediately and drops all valids; in-flight bursts are abandoned.

Optional Feature:
- MME_PERF_CNT_EN defined: adds RO register 0x214 PERF_CYCLES.
  - Cleared on start.
  - Increments every cycle the FSM is not IDLE.
  - Holds its value after done.
- MME_PERF_CNT_EN undefined: 0x214 reads 0 and no counter is built.

Test Plan:
- Reset, then read 0x000 -> IP_VERSION; read 0x210 -> 0.
- Write 0x100=4, 0x200=0x0, 0x204=0x1000, 0x208=0x2000, then read each back -> identical values.
- N=4, random bytes 0..255 in A/B, CMD=1, poll STATUS -> 1. C at 0x2000 matches the reference product. AXI traffic: 8 read bursts of len 3, 1 write burst of len 15.
- Repeat for N=8, 12 and 16 back-to-back without reset -> each C correct; done clears on each start.
- N=4 with A=B=0x7FFFFFFF -> each C element = low 32 bits of 4*(2^31-1)^2. Random arready/rvalid/wready/bvalid stalls -> same result.
- CMD=1 issued while busy -> no second operation. rst_n low mid-read -> valids drop and STATUS=0; a new run then completes correctly.
